// File: rtl/x68k_ldr_pkg.sv
// Shared types and default sizes for the ioctl-to-loader bridge.
package x68k_ldr_pkg;

  localparam int LDR_DEPTH = 4;
  localparam int LDR_AW    = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ldr_state_t;

  typedef struct packed {
    logic [LDR_AW-1:0] addr;
    logic [7:0]        data;
  } ldr_entry_t;

endpackage

// File: rtl/ioctl_ldr_bridge_if.sv
// hps_io ioctl download port plus X68K loader port, as seen by the bridge.
interface ioctl_ldr_bridge_if import x68k_ldr_pkg::*; #(
  parameter int AW = LDR_AW
) ();

  logic          ioctl_download;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wait;
  logic          ldr_aen;
  logic [AW-1:0] ldr_addr;
  logic [7:0]    ldr_wdat;
  logic          ldr_wr;
  logic          ldr_ack;
  logic          ldr_done;
  logic [AW:0]   load_cnt;
  logic          range_err;
  logic          ovf_err;

  // Bridge side.
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
    output ioctl_wait, ldr_aen, ldr_addr, ldr_wdat, ldr_wr, ldr_done,
           load_cnt, range_err, ovf_err
  );

  // HPS plus core side.
  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
    input  ioctl_wait, ldr_aen, ldr_addr, ldr_wdat, ldr_wr, ldr_done,
           load_cnt, range_err, ovf_err
  );

endinterface

// File: rtl/ldr_fifo.sv
// Single-clock circular FIFO; push when full and pop when empty are ignored.
module ldr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 28
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_sys) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ioctl_ldr_bridge.sv
// Buffers hps_io ioctl download bytes and replays them to the X68K loader port.
//   state | meaning
//   IDLE  | waiting for the first download window
//   LOAD  | download open: accept ioctl bytes, feed the core
//   DRAIN | download closed: flush buffered bytes to the core
//   DONE  | load finished; terminal until reset, later downloads ignored
module ioctl_ldr_bridge import x68k_ldr_pkg::*; #(
  parameter int DEPTH = LDR_DEPTH,
  parameter int AW    = LDR_AW
) (
  input  logic             clk_sys,
  input  logic             reset,
  ioctl_ldr_bridge_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = AW + 8;
  localparam logic [CW-1:0] WAIT_TH = CW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_MAX = {1'b1, {AW{1'b0}}};

  ldr_state_t    state_q, state_d;
  logic          dl_q, ack_q;
  logic          ldr_wr_q, ldr_wr_d;
  logic [AW-1:0] ldr_addr_q, ldr_addr_d;
  logic [7:0]    ldr_wdat_q, ldr_wdat_d;
  logic          ldr_done_q, ldr_done_d;
  logic [AW:0]   load_cnt_q, load_cnt_d;
  logic          range_err_q, range_err_d;
  logic          ovf_err_q, ovf_err_d;
  logic          ioctl_wait_q, ioctl_wait_d;

  logic          dl_rise, dl_fall, active, in_range, wr_load;
  logic          push, pop, ack_hit;
  logic [EW-1:0] fifo_dout;
  logic [CW-1:0] fifo_count, count_next;
  logic          fifo_full, fifo_empty;

  assign dl_rise  = bus.ioctl_download && !dl_q;
  assign dl_fall  = !bus.ioctl_download && dl_q;
  assign active   = (state_q == LOAD) || (state_q == DRAIN);
  assign in_range = (bus.ioctl_addr[24:AW] == '0);
  assign wr_load  = (state_q == LOAD) && bus.ioctl_wr;
  assign push     = wr_load && in_range && !fifo_full;
  assign pop      = active && !fifo_empty && !ldr_wr_q;
  assign ack_hit  = bus.ldr_ack && !ack_q && ldr_wr_q;

  ldr_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .din     ({bus.ioctl_addr[AW-1:0], bus.ioctl_dout}),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (dl_rise) state_d = LOAD;
      LOAD:    if (dl_fall) state_d = DRAIN;
      DRAIN:   if (fifo_empty && !ldr_wr_q) state_d = DONE;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    ldr_wr_d    = ldr_wr_q;
    ldr_addr_d  = ldr_addr_q;
    ldr_wdat_d  = ldr_wdat_q;
    load_cnt_d  = load_cnt_q;
    range_err_d = range_err_q || (wr_load && !in_range);
    // Out-of-range wins over overflow when both apply.
    ovf_err_d   = ovf_err_q || (wr_load && in_range && fifo_full);
    if (ack_hit) begin
      ldr_wr_d = 1'b0;
      if (load_cnt_q != CNT_MAX) load_cnt_d = load_cnt_q + (AW+1)'(1);
    end
    if (pop) begin
      ldr_wr_d   = 1'b1;
      ldr_addr_d = fifo_dout[EW-1:8];
      ldr_wdat_d = fifo_dout[7:0];
    end
    // Wait reflects the post-edge occupancy, leaving one slot for an in-flight write.
    count_next   = fifo_count + CW'(push) - CW'(pop);
    ioctl_wait_d = (count_next >= WAIT_TH);
    ldr_done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      dl_q         <= 1'b0;
      ack_q        <= 1'b0;
      ldr_wr_q     <= 1'b0;
      ldr_addr_q   <= '0;
      ldr_wdat_q   <= '0;
      ldr_done_q   <= 1'b0;
      load_cnt_q   <= '0;
      range_err_q  <= 1'b0;
      ovf_err_q    <= 1'b0;
      ioctl_wait_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dl_q         <= bus.ioctl_download;
      ack_q        <= bus.ldr_ack;
      ldr_wr_q     <= ldr_wr_d;
      ldr_addr_q   <= ldr_addr_d;
      ldr_wdat_q   <= ldr_wdat_d;
      ldr_done_q   <= ldr_done_d;
      load_cnt_q   <= load_cnt_d;
      range_err_q  <= range_err_d;
      ovf_err_q    <= ovf_err_d;
      ioctl_wait_q <= ioctl_wait_d;
    end
  end

  assign bus.ioctl_wait = ioctl_wait_q;
  assign bus.ldr_aen    = active;
  assign bus.ldr_addr   = ldr_addr_q;
  assign bus.ldr_wdat   = ldr_wdat_q;
  assign bus.ldr_wr     = ldr_wr_q;
  assign bus.ldr_done   = ldr_done_q;
  assign bus.load_cnt   = load_cnt_q;
  assign bus.range_err  = range_err_q;
  assign bus.ovf_err    = ovf_err_q;

endmodule

// File: doc/ioctl_ldr_bridge.md
Name: ioctl_ldr_bridge

Overview:
- Sits between the hps_io ioctl download port and the X68K_top loader port (ldr_*), and replaces the ad-hoc ldr_wr/ldr_done glue in the emu top.
- Buffers ioctl byte writes in a small FIFO and replays them to the core over a level-request / edge-acknowledge handshake.
- Back-pressures the HPS through ioctl_wait and flags the end of the boot-ROM load with a sticky ldr_done.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- AW, 20: loader address width; ioctl addresses at or above 2^AW are out of range.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download window from hps_io.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  back-pressure to hps_io.
- ldr_aen  out  1  loader owns the core memory bus.
- ldr_addr  out  AW  write address.
- ldr_wdat  out  8  write data.
- ldr_wr  out  1  write request; held high until acknowledged.
- ldr_ack  in  1  core acknowledge; only its rising edge is used.
- ldr_done  out  1  sticky: load finished.
- load_cnt  out  AW+1  bytes delivered to the core.
- range_err  out  1  sticky: an out-of-range byte was dropped.
- ovf_err  out  1  sticky: a write arrived while the FIFO was full and was dropped.

Behaviour:
- Reset: all of the following are 0 — ioctl_wait, ldr_aen, ldr_addr, ldr_wdat, ldr_wr, ldr_done, load_cnt, range_err, ovf_err, FIFO count. The internal ack_q register is also 0 and the FSM goes to IDLE. Reset mid-load abandons all buffered bytes.
- FSM states:
  - IDLE → LOAD on the rising edge of ioctl_download.
  - LOAD → DRAIN on the falling edge of ioctl_download.
  - DRAIN → DONE when the FIFO is empty and ldr_wr=0.
  - DONE is terminal until reset. A second download is ignored: no pushes, ioctl_wait=0, and nothing is flagged.
- ldr_aen = 1 in LOAD and DRAIN, 0 in IDLE and DONE. ldr_done = 1 only in DONE; it is registered in the same edge as the DRAIN→DONE transition.
- Push, in LOAD only: an ioctl_wr byte is pushed if ioctl_addr[24:AW]==0 and count<DEPTH.
  - If ioctl_addr[24:AW]!=0, the byte is dropped and range_err is set.
  - If count==DEPTH, the byte is dropped and ovf_err is set.
  - If both apply, only range_err is set.
- ioctl_wait = (count >= DEPTH-1), registered. This one-entry margin absorbs the one write hps_io may issue before it sees wait.
- Pop:
  - Condition: in LOAD or DRAIN, with count>0 and ldr_wr=0.
  - On the pop edge, ldr_addr/ldr_wdat load the head entry and ldr_wr goes to 1.
  - ldr_addr/ldr_wdat stay stable while ldr_wr=1.
- Latency: ioctl_wr sampled at edge t lands in the FIFO at t. With the FIFO previously empty and ldr_wr=0, ldr_wr=1 at edge t+1.
- Acknowledge: ack_q <= ldr_ack every cycle. If ldr_ack & ~ack_q & ldr_wr, then at that edge ldr_wr goes to 0 and load_cnt increments.
  - The next pop happens at the following edge at the earliest.
  - Sustained throughput: one byte per 2 cycles plus the ack delay.
  - An ack edge while ldr_wr=0 is ignored.
  - ldr_ack held high does not re-trigger.
- Simultaneous push and pop: count is unchanged. The FIFO is a circular buffer with AW+8-bit entries; pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- load_cnt saturates at 2^AW.
- Download falling while ldr_wr=1: the FSM enters DRAIN, the outstanding write completes normally, and the remaining entries drain.
- ioctl_wr on the same cycle ioctl_download falls: the byte is accepted, because the state is still LOAD at that edge.

Decomposition:
- x68k_ldr_pkg holds:
  - typedef ldr_state_t {IDLE, LOAD, DRAIN, DONE}
  - struct ldr_entry_t {addr, data}
  - the default-parameter constants
- One sub-module, ldr_fifo: synchronous single-clock FIFO with push, pop, count, full and empty outputs, parameterised on DEPTH and entry width.

Test Plan:
- Single byte: download rises; ioctl_wr addr 0x00010, data 0xA5; core acks 3 cycles after ldr_wr → ldr_addr=0x00010, ldr_wdat=0xA5; ldr_wr high exactly from t+1 until the ack edge; load_cnt=1.
- Slow core: 16 back-to-back-capable writes, ack 10 cycles after each ldr_wr → ioctl_wait asserts at count 3; HPS honouring wait gives all 16 bytes delivered in order; ovf_err=0.
- Overflow and range: ignore wait and write 6 bytes with no ack → 4 stored, ovf_err=1. A byte at addr 0x100000 → dropped, range_err=1, load_cnt unchanged.
- End of load: download falls with 3 entries buffered → ldr_aen stays 1; ldr_done rises the cycle after the third ack's edge; ldr_aen=0 with it; load_cnt=3.
- Ack held high and spurious edges: ldr_ack stuck at 1 across two requests → only the first completes; an ack pulse while ldr_wr=0 → no count change.
- Reset mid-load and re-download: reset with 2 bytes buffered and ldr_wr=1 → all outputs 0 next cycle. A download after DONE → ioctl_wait=0, no ldr_wr activity, ldr_done stays 1.
